// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Holds state encoding and register-specifier constants.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MDU_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: EX load feeding a source of the ID instruction.
// Register $zero never creates a dependency.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             uses_rt,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = uses_rt && (ex_rt == id_rt);
  assign hazard = mem_read && (ex_rt != REG_ZERO)
               && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (Mealy outputs).
// Optional stall-cycle counter enabled by HAZ_STALL_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IDEX_MemRead,
  input  logic [REG_W-1:0]     IDEX_Rt,
  input  logic                 IDEX_MduOp,
  input  logic [REG_W-1:0]     IFID_Rs,
  input  logic [REG_W-1:0]     IFID_Rt,
  input  logic                 IFID_UsesRt,
  input  logic                 BranchTaken,
  input  logic                 Jump,
  output logic                 PCWrite,
  output logic                 IFID_Write,
  output logic                 IFID_Flush,
  output logic                 IDEX_Write,
  output logic                 IDEX_Bubble,
  output logic                 EXMEM_Bubble,
  output logic                 Busy,
  output logic [CNT_WIDTH-1:0] StallCount
);

  localparam int MW = $clog2(MDU_LATENCY) + 1;
  localparam bit MDU_MULTI = (MDU_LATENCY > 1);
  localparam logic [MW-1:0] MDU_LOAD =
    MDU_MULTI ? MW'(MDU_LATENCY - 2) : '0;

  state_t        state;
  state_t        state_nx;
  logic [MW-1:0] mdu_cnt;
  logic [MW-1:0] mdu_cnt_nx;
  logic          load_use;

  load_use_detect u_lud (
    .mem_read (IDEX_MemRead),
    .ex_rt    (IDEX_Rt),
    .id_rs    (IFID_Rs),
    .id_rt    (IFID_Rt),
    .uses_rt  (IFID_UsesRt),
    .hazard   (load_use)
  );

  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    state_nx     = state;
    mdu_cnt_nx   = mdu_cnt;
    if (reset) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
      EXMEM_Bubble = 1'b1;
      state_nx     = ST_RUN;
      mdu_cnt_nx   = '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if (IDEX_MduOp && MDU_MULTI) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            mdu_cnt_nx   = MDU_LOAD;
            state_nx     = ST_MDU_WAIT;
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            state_nx    = ST_LOAD_STALL;
          end else if (Jump) begin
            IFID_Flush = 1'b1;
          end
        end
        ST_LOAD_STALL: begin
          if (BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if (Jump) begin
            IFID_Flush = 1'b1;
          end
          state_nx = ST_RUN;
        end
        ST_MDU_WAIT: begin
          if (mdu_cnt != '0) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            mdu_cnt_nx   = mdu_cnt - 1'b1;
          end else begin
            IFID_Flush = Jump;
            state_nx   = ST_RUN;
          end
        end
        default: begin
          state_nx   = ST_RUN;
          mdu_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state   <= state_nx;
    mdu_cnt <= mdu_cnt_nx;
  end

  assign Busy = !reset && (state != ST_RUN);

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!PCWrite && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule
